pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/cpu_pkg.sv | 14 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipeline_controller.sv | 145 ++++++++++++++
 tb/tb_pipeline_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the pipeline control slice: FSM states and stage indices.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// In-order pipeline control: load-use stall, taken-branch flush, halt/drain FSM
// and saturating cycle/retire/stall performance counters.
module pipeline_controller
  import cpu_pkg::*;
#(
  parameter int RA_W   = 3,
  parameter int STAGES = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              ex_load,
  input  logic              ex_wr_en,
  input  logic [RA_W-1:0]   ex_wr_reg,
  input  logic              br_taken,
  input  logic              halt_req,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_flush,
  output logic [STAGES-1:0] stage_valid,
  output logic              donebit,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  ret_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_q, state_d;
  logic [STAGES-1:1] vld_q, vld_d;
  logic              donebit_q;

  logic is_run, is_drain, is_halted;
  logic src_hit, stall_raw, br_eff, stall;

  // Encoding 3 is unreachable but behaves as HALTED.
  assign is_run    = (state_q == ST_RUN);
  assign is_drain  = (state_q == ST_DRAIN);
  assign is_halted = !is_run && !is_drain;

  // Load-use hazard; register 0 is an ordinary register here, so it can stall too.
  assign src_hit   = (id_use1 && (id_rs1 == ex_wr_reg)) ||
                     (id_use2 && (id_rs2 == ex_wr_reg));
  assign stall_raw = is_run && vld_q[STG_D] && vld_q[STG_E] &&
                     ex_load && ex_wr_en && src_hit;
  // A branch with no live instruction in E is stale and ignored.
  assign br_eff    = br_taken && vld_q[STG_E] && !is_halted;
  assign stall     = stall_raw && !br_eff;

  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    vld_d    = {vld_q[STAGES-2:1], is_run};
    case (state_q)
      ST_RUN: begin
        if (br_eff) begin
          pc_en        = 1'b1;
          fd_en        = 1'b1;
          fd_flush     = 1'b1;
          de_flush     = 1'b1;
          vld_d[STG_D] = 1'b0;
          vld_d[STG_E] = 1'b0;
        end else if (stall) begin
          de_flush     = 1'b1;
          vld_d[STG_D] = vld_q[STG_D];
          vld_d[STG_E] = 1'b0;
        end else if (halt_req && vld_q[STG_D]) begin
          // The halt instruction itself is squashed on its way into E.
          fd_flush     = 1'b1;
          de_flush     = 1'b1;
          vld_d[STG_D] = 1'b0;
          vld_d[STG_E] = 1'b0;
          state_d      = ST_DRAIN;
        end else begin
          pc_en = 1'b1;
          fd_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        fd_flush     = 1'b1;
        vld_d[STG_D] = 1'b0;
        if (br_eff) begin
          de_flush     = 1'b1;
          vld_d[STG_E] = 1'b0;
        end
        if (vld_q[STAGES-1:STG_E] == '0) begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        vld_d   = '0;
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      vld_q     <= '0;
      donebit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      donebit_q <= (state_d == ST_HALTED);
    end
  end

  assign stage_valid[STG_F]        = is_run;
  assign stage_valid[STAGES-1:1]   = vld_q;
  assign donebit                   = donebit_q;
  assign state                     = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (!is_halted),
    .count (cyc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (vld_q[STAGES-1]),
    .count (ret_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios plus random traffic against a behavioural model.
module tb_pipeline_controller;

  localparam int RA_W   = 3;
  localparam int STAGES = 5;
  localparam int CW     = 16;
  localparam int CW4    = 4;

  logic clk = 1'b0;
  logic reset;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_wr_reg;
  logic id_use1, id_use2, ex_load, ex_wr_en, br_taken, halt_req;

  logic pc_en, fd_en, fd_flush, de_flush, donebit;
  logic [STAGES-1:0] stage_valid;
  logic [1:0] state;
  logic [CW-1:0] cyc_cnt, ret_cnt, stall_cnt;

  logic pc_en_4, fd_en_4, fd_flush_4, de_flush_4, donebit_4;
  logic [STAGES-1:0] stage_valid_4;
  logic [1:0] state_4;
  logic [CW4-1:0] cyc_cnt_4, ret_cnt_4, stall_cnt_4;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: occupancy per stage, FSM phase, raw event counts.
  int          m_state;
  logic [STAGES-1:0] m_v;
  int unsigned m_cyc, m_ret, m_stl;

  always #5 clk = ~clk;

  pipeline_controller #(.RA_W(RA_W), .STAGES(STAGES), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .ex_load(ex_load), .ex_wr_en(ex_wr_en),
    .ex_wr_reg(ex_wr_reg), .br_taken(br_taken), .halt_req(halt_req),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .stage_valid(stage_valid), .donebit(donebit), .state(state),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt)
  );

  pipeline_controller #(.RA_W(RA_W), .STAGES(STAGES), .CNT_W(CW4)) u_dut4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .ex_load(ex_load), .ex_wr_en(ex_wr_en),
    .ex_wr_reg(ex_wr_reg), .br_taken(br_taken), .halt_req(halt_req),
    .pc_en(pc_en_4), .fd_en(fd_en_4), .fd_flush(fd_flush_4), .de_flush(de_flush_4),
    .stage_valid(stage_valid_4), .donebit(donebit_4), .state(state_4),
    .cyc_cnt(cyc_cnt_4), .ret_cnt(ret_cnt_4), .stall_cnt(stall_cnt_4)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned x, input int w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
    return (x > lim) ? lim : x;
  endfunction

  task automatic model_clear();
    m_state = 0;
    m_v     = '0;
    m_cyc   = 0;
    m_ret   = 0;
    m_stl   = 0;
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; id_use1 = 0; id_use2 = 0;
    ex_load = 0; ex_wr_en = 0; ex_wr_reg = '0; br_taken = 0; halt_req = 0;
  endtask

  task automatic set_reset(input logic r);
    reset = r;
    if (r) model_clear();
  endtask

  // One clock: check every output mid-cycle against the model, then advance the model.
  task automatic step();
    logic run, drain, halted, hit, branch, stl, halt_go;
    logic e_pc, e_fd, e_fdf, e_def;
    logic [STAGES-1:0] sv, nv;
    int ns;
    @(negedge clk);
    run    = (m_state == 0);
    drain  = (m_state == 1);
    halted = (m_state == 2);
    sv     = m_v;
    sv[0]  = run;
    hit     = (id_use1 && id_rs1 == ex_wr_reg) || (id_use2 && id_rs2 == ex_wr_reg);
    branch  = br_taken && sv[2] && !halted;
    stl     = run && sv[1] && sv[2] && ex_load && ex_wr_en && hit && !branch;
    halt_go = run && halt_req && sv[1] && !stl && !branch;
    if (halted)       {e_pc, e_fd, e_fdf, e_def} = 4'b0000;
    else if (drain)   {e_pc, e_fd, e_fdf, e_def} = {3'b001, branch};
    else if (branch)  {e_pc, e_fd, e_fdf, e_def} = 4'b1111;
    else if (stl)     {e_pc, e_fd, e_fdf, e_def} = 4'b0001;
    else if (halt_go) {e_pc, e_fd, e_fdf, e_def} = 4'b0011;
    else              {e_pc, e_fd, e_fdf, e_def} = 4'b1100;

    check("stage_valid", stage_valid, sv);
    check("state", state, m_state);
    check("donebit", donebit, halted);
    check("pc_en", pc_en, e_pc);
    check("fd_en", fd_en, e_fd);
    check("fd_flush", fd_flush, e_fdf);
    check("de_flush", de_flush, e_def);
    check("cyc_cnt", cyc_cnt, sat(m_cyc, CW));
    check("ret_cnt", ret_cnt, sat(m_ret, CW));
    check("stall_cnt", stall_cnt, sat(m_stl, CW));
    check("cyc_cnt_w4", cyc_cnt_4, sat(m_cyc, CW4));
    check("ret_cnt_w4", ret_cnt_4, sat(m_ret, CW4));
    check("stall_cnt_w4", stall_cnt_4, sat(m_stl, CW4));

    nv = '0;
    for (int k = STAGES - 1; k >= 1; k--) nv[k] = sv[k-1];
    ns = m_state;
    if (halted) begin
      nv = '0;
    end else if (drain) begin
      nv[1] = 1'b0;
      if (branch) nv[2] = 1'b0;
      if (sv[STAGES-1:2] == '0) ns = 2;
    end else if (branch) begin
      nv[1] = 1'b0; nv[2] = 1'b0;
    end else if (stl) begin
      nv[1] = sv[1]; nv[2] = 1'b0;
    end else if (halt_go) begin
      nv[1] = 1'b0; nv[2] = 1'b0; ns = 1;
    end

    @(posedge clk);
    if (!reset) begin
      m_v     = nv;
      m_state = ns;
      m_cyc  += (halted ? 0 : 1);
      m_ret  += (sv[STAGES-1] ? 1 : 0);
      m_stl  += (stl ? 1 : 0);
    end
    #1;
  endtask

  task automatic fresh_start(input int fill);
    set_idle();
    set_reset(1'b1);
    step();
    set_reset(1'b0);
    for (int i = 0; i < fill; i++) step();
  endtask

  task automatic set_stall_inputs();
    ex_load = 1; ex_wr_en = 1; ex_wr_reg = 3'd3; id_rs2 = 3'd3; id_use2 = 1;
  endtask

  initial begin
    set_idle();
    set_reset(1'b1);
    step();
    step();
    set_reset(1'b0);

    // Idle run: pipe fills in 4 edges, W retires from edge 5 on.
    for (int i = 0; i < 4; i++) step();
    check("fill_full", stage_valid, 5'b11111);
    for (int i = 0; i < 6; i++) step();
    check("idle_ret6", ret_cnt, 6);
    check("idle_cyc10", cyc_cnt, 10);

    // Load-use stall on rs2.
    fresh_start(5);
    set_stall_inputs();
    #1;
    check("stall_pc_en", pc_en, 0);
    check("stall_de_flush", de_flush, 1);
    step();
    set_idle();
    check("stall_cnt1", stall_cnt, 1);
    check("stall_e_bubble", stage_valid[2], 0);

    // Branch beats a simultaneous stall.
    fresh_start(5);
    set_stall_inputs();
    br_taken = 1;
    #1;
    check("br_fd_flush", fd_flush, 1);
    check("br_de_flush", de_flush, 1);
    check("br_pc_en", pc_en, 1);
    step();
    set_idle();
    check("br_stall_cnt0", stall_cnt, 0);

    // Halt at full pipe: DRAIN for three cycles, then HALTED with counters frozen.
    fresh_start(5);
    halt_req = 1;
    step();
    halt_req = 0;
    check("halt_drain", state, 1);
    step();
    step();
    check("drain_no_done", donebit, 0);
    step();
    check("halted_state", state, 2);
    check("halted_done", donebit, 1);
    for (int i = 0; i < 4; i++) step();
    check("halted_cyc_frozen", cyc_cnt, 9);
    check("halted_ret", ret_cnt, 4);

    // Narrow counters saturate.
    fresh_start(20);
    check("sat_cyc_w4", cyc_cnt_4, 15);
    check("sat_ret_w4", ret_cnt_4, 15);

    // Reset while draining takes effect immediately.
    fresh_start(5);
    halt_req = 1;
    step();
    halt_req = 0;
    step();
    set_reset(1'b1);
    #1;
    check("rst_state", state, 0);
    check("rst_done", donebit, 0);
    check("rst_cyc", cyc_cnt, 0);
    check("rst_ret", ret_cnt, 0);
    check("rst_valid", stage_valid, 5'b00001);
    step();
    set_reset(1'b0);

    // Random traffic with occasional halts and resets.
    for (int c = 0; c < 4000; c++) begin
      id_rs1    = RA_W'($urandom_range(0, 3));
      id_rs2    = RA_W'($urandom_range(0, 3));
      ex_wr_reg = RA_W'($urandom_range(0, 3));
      id_use1   = 1'($urandom_range(0, 1));
      id_use2   = 1'($urandom_range(0, 1));
      ex_load   = 1'($urandom_range(0, 1));
      ex_wr_en  = ($urandom_range(0, 3) != 0);
      br_taken  = ($urandom_range(0, 7) == 0);
      halt_req  = ($urandom_range(0, 39) == 0);
      if (reset) set_reset(1'b0);
      else if ((m_state == 2 && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0)
        set_reset(1'b1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
